spi_master: RTL and testbench

// - Master end of the team's SPI register-access protocol: drives cs, sclk, mosi; samples miso.
// - Frame: 16 sclk cycles, MSB first:
//   - addr[6:0], then rw (1 = read, 0 = write), then data[7:0].
// - Sits between the system-clock host logic and an SPI slave/data memory, for example in a loopback bench.
// - Single clk domain; sclk is a divided, registered copy of clk.

---
 rtl/spi_master_pkg.sv | 29 ++
 rtl/spi_master_if.sv | 32 +++
 rtl/spi_master_sclk_gen.sv | 57 +++++
 rtl/spi_master.sv | 183 ++++++++++++++++++
 tb/tb_spi_master.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI register-access protocol, used by both the
// master and the slave side.
//   - spi_state_e : 3-bit state encoding of the master FSM
//   - SPI_ADDR_W / SPI_DATA_W / SPI_FRAME_BITS : fixed frame geometry
//   - spi_frame() : builds the 16-bit on-wire frame {addr, rw, data}
package spi_master_pkg;

  typedef enum logic [2:0] {
    SPI_IDLE  = 3'd0,
    SPI_SETUP = 3'd1,
    SPI_SHIFT = 3'd2,
    SPI_HOLD  = 3'd3,
    SPI_GAP   = 3'd4
  } spi_state_e;

  localparam int SPI_ADDR_W     = 7;
  localparam int SPI_DATA_W     = 8;
  localparam int SPI_FRAME_BITS = SPI_ADDR_W + 1 + SPI_DATA_W;

  // Reads carry a zero data field; the slave drives the data on miso instead.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  rw,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {addr, rw, (rw ? {SPI_DATA_W{1'b0}} : wdata)};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the host-side request/response signals and the four SPI wires.
//   Host side : start, rw, addr, wdata (requests)  busy, done, rdata (status)
//   SPI side  : cs (active low), sclk, mosi (driven by master)  miso (by slave)
// Modports:
//   master : the spi_master block itself
//   slave  : everything on the far side (host logic plus SPI slave)
interface spi_master_if;
  import spi_master_pkg::*;

  logic                  start;
  logic                  rw;
  logic [SPI_ADDR_W-1:0] addr;
  logic [SPI_DATA_W-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [SPI_DATA_W-1:0] rdata;
  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, cs, sclk, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, cs, sclk, mosi
  );

endinterface

// File: rtl/spi_master_sclk_gen.sv
// Serial clock generator for the SPI master.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   en_i   in  run the divider; while low sclk is held low and the count cleared
//   sclk_o out registered serial clock, CLK_DIV clk cycles per half-period
//   rise_o out one-cycle strobe: sclk goes 0->1 at the coming clk edge
//   fall_o out one-cycle strobe: sclk goes 1->0 at the coming clk edge
module spi_master_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       sclk_q, sclk_d;
  logic       wrap;

  // The strobes announce the toggle on the same edge that performs it, so the
  // FSM can act on the edge in lock-step with sclk.
  assign wrap = en_i && (div_q == HALF_LAST);

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap &&  sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI master for the register-access protocol. One 16-bit frame per request,
// MSB first: addr[6:0], rw, data[7:0]. cs/sclk/mosi are all flop outputs.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (releases cs immediately)
//   bus    spi_master_if.master
//            start/rw/addr/wdata in : request, latched when accepted
//            busy/done/rdata     out: status and read result
//            cs/sclk/mosi        out: SPI wires; miso in: slave data
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = SPI_ADDR_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int         FRAME_W        = ADDR_W + 1 + DATA_W;
  localparam logic [8:0] DIV_LAST       = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST       = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT       = 4'(FRAME_W - 1);
  localparam logic [3:0] FIRST_DATA_BIT = 4'(ADDR_W + 1);

  spi_state_e         state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [3:0]         bit_q, bit_d;
  logic               rw_q, rw_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               sclk_w, rise_w, fall_w;
  logic               accept_w;
  logic [FRAME_W-1:0] frame_w;

  spi_master_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == SPI_SHIFT),
    .sclk_o (sclk_w),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  // start is looked at in IDLE and on the closing cycle of GAP. Accepting on
  // the last GAP cycle is what makes the cs-high time between back-to-back
  // frames exactly 2*CLK_DIV instead of 2*CLK_DIV+1.
  assign accept_w = bus.start &&
                    ((state_q == SPI_IDLE) ||
                     ((state_q == SPI_GAP) && (cnt_q == GAP_LAST)));

  assign frame_w = spi_frame(bus.addr, bus.rw, bus.wdata);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SPI_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic. cnt_q times SETUP/HOLD/GAP and restarts on every state
  // change; SHIFT is paced by the sclk generator instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 9'd1;
    case (state_q)
      SPI_IDLE: begin
        cnt_d = '0;
        if (accept_w) state_d = SPI_SETUP;
      end
      SPI_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SPI_SHIFT;
          cnt_d   = '0;
        end
      end
      SPI_SHIFT: begin
        cnt_d = '0;
        if (fall_w && (bit_q == LAST_BIT)) state_d = SPI_HOLD;
      end
      SPI_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SPI_GAP;
          cnt_d   = '0;
        end
      end
      SPI_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = accept_w ? SPI_SETUP : SPI_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SPI_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      SPI_IDLE, SPI_GAP: begin
        if (accept_w) begin
          tx_d   = frame_w;
          rw_d   = bus.rw;
          rx_d   = '0;
          bit_d  = '0;
          cs_d   = 1'b0;
          busy_d = 1'b1;
          mosi_d = frame_w[FRAME_W-1];
        end
      end
      SPI_SHIFT: begin
        // Data bits of a read are captured on the rising edge.
        if (rise_w && rw_q && (bit_q >= FIRST_DATA_BIT)) begin
          rx_d = {rx_q[DATA_W-2:0], bus.miso};
        end
        if (fall_w) begin
          tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
          bit_d  = bit_q + 4'd1;
          mosi_d = (bit_q == LAST_BIT) ? 1'b0 : tx_q[FRAME_W-2];
        end
      end
      SPI_HOLD: begin
        // Last HOLD cycle: release cs and report completion on the first GAP cycle.
        if (cnt_q == DIV_LAST) begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          if (rw_q) rdata_d = rx_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.cs    = cs_q;
  assign bus.sclk  = sclk_w;
  assign bus.mosi  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: one instance at CLK_DIV=4 and one at
// CLK_DIV=2, a passive wire monitor and a behavioural SPI slave on miso.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if bus_a();
  spi_master_if bus_b();

  spi_master #(.CLK_DIV(DIV_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  spi_master #(.CLK_DIV(DIV_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // ---------------- reference model ----------------
  function automatic logic [15:0] exp_frame(input logic [6:0] a, input logic r,
                                            input logic [7:0] w);
    logic [15:0] f;
    f = {a, r, 8'h00};
    if (!r) f = f + {8'h00, w};
    return f;
  endfunction

  logic [7:0] rd_model = 8'h00;

  // ---------------- slave model on miso ----------------
  // After k sclk falls the slave presents frame bit k; data bits 8..15 carry
  // the slave byte MSB first, everything else is noise.
  logic [7:0] sb_a = 8'h00;
  logic       noise_a = 1'b0;
  int         fall_a = 0;

  function automatic logic miso_model(input int k, input logic [7:0] s, input logic n);
    int idx;
    if (k >= 8 && k < 16) begin
      idx = 15 - k;
      return s[idx[2:0]];
    end
    return n;
  endfunction

  assign bus_a.miso = miso_model(fall_a, sb_a, noise_a);
  assign bus_b.miso = 1'b0;

  // ---------------- monitor A ----------------
  logic        prev_sclk_a = 1'b0, prev_cs_a = 1'b1;
  logic [15:0] mosi_cap_a = '0, frame_at_done_a = '0;
  logic [7:0]  rdata_at_done_a = '0;
  logic        busy_at_done_a = 1'b0;
  int          cs_low_a = 0, cs_high_run_a = 0, cs_fall_a = 0;
  int          done_cnt_a = 0, done_cyc_a = 0, cs_low_at_done_a = 0;
  int          gap_q[$];
  int          done_q[$];

  always @(negedge clk) begin
    if (bus_a.sclk && !prev_sclk_a) mosi_cap_a <= {mosi_cap_a[14:0], bus_a.mosi};
    if (!bus_a.sclk && prev_sclk_a) begin
      fall_a  <= fall_a + 1;
      noise_a <= 1'($urandom);
    end
    if (!bus_a.cs && prev_cs_a) begin
      cs_fall_a <= cs_fall_a + 1;
      gap_q.push_back(cs_high_run_a);
      cs_high_run_a <= 0;
      cs_low_a      <= 1;
      mosi_cap_a    <= '0;
      fall_a        <= 0;
    end else if (!bus_a.cs) begin
      cs_low_a <= cs_low_a + 1;
    end else begin
      cs_high_run_a <= cs_high_run_a + 1;
    end
    if (bus_a.done) begin
      done_cnt_a       <= done_cnt_a + 1;
      done_cyc_a       <= cyc;
      frame_at_done_a  <= mosi_cap_a;
      rdata_at_done_a  <= bus_a.rdata;
      busy_at_done_a   <= bus_a.busy;
      cs_low_at_done_a <= cs_low_a;
      done_q.push_back(cyc);
    end
    prev_sclk_a <= bus_a.sclk;
    prev_cs_a   <= bus_a.cs;
  end

  // ---------------- monitor B ----------------
  logic        prev_sclk_b = 1'b0, prev_cs_b = 1'b1;
  logic [15:0] mosi_cap_b = '0, frame_at_done_b = '0;
  int          last_rise_b = 0, rises_b = 0, per_min_b = 0, per_max_b = 0;
  int          done_cnt_b = 0, done_cyc_b = 0;

  always @(negedge clk) begin
    if (bus_b.sclk && !prev_sclk_b) begin
      mosi_cap_b  <= {mosi_cap_b[14:0], bus_b.mosi};
      rises_b     <= rises_b + 1;
      last_rise_b <= cyc;
      if (rises_b > 0) begin
        if (rises_b == 1 || (cyc - last_rise_b) < per_min_b) per_min_b <= cyc - last_rise_b;
        if (rises_b == 1 || (cyc - last_rise_b) > per_max_b) per_max_b <= cyc - last_rise_b;
      end
    end
    if (!bus_b.cs && prev_cs_b) begin
      mosi_cap_b <= '0;
      rises_b    <= 0;
    end
    if (bus_b.done) begin
      done_cnt_b      <= done_cnt_b + 1;
      done_cyc_b      <= cyc;
      frame_at_done_b <= mosi_cap_b;
    end
    prev_sclk_b <= bus_b.sclk;
    prev_cs_b   <= bus_b.cs;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic launch_a(input logic [6:0] a, input logic r, input logic [7:0] w,
                          input logic [7:0] s, output int acc);
    @(posedge clk); #1;
    sb_a = s;
    bus_a.addr = a; bus_a.rw = r; bus_a.wdata = w; bus_a.start = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt_a > d0) ok = 1'b1;
    end
  endtask

  task automatic wait_falls_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (fall_a >= n) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.cs !== 1'b1)    begin errors++; $display("FAIL reset_cs: got %b want 1", bus_a.cs); end
    checks++; if (bus_a.sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b want 0", bus_a.sclk); end
    checks++; if (bus_a.mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi: got %b want 0", bus_a.mosi); end
    checks++; if (bus_a.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    checks++; if (bus_a.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
    checks++; if (bus_a.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus_a.rdata); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_a.cs !== 1'b1 || bus_a.busy !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got cs=%b busy=%b want cs=1 busy=0", bus_a.cs, bus_a.busy); end
    $display("txn reset released at cycle %0d", cyc);
  endtask

  task automatic test_write();
    int acc; bit ok; int d0;
    d0 = done_cnt_a;
    launch_a(7'h2A, 1'b0, 8'hC3, 8'hFF, acc);
    checks++; if (bus_a.cs !== 1'b0 || bus_a.busy !== 1'b1)
      begin errors++; $display("FAIL write_accept: got cs=%b busy=%b want cs=0 busy=1", bus_a.cs, bus_a.busy); end
    wait_done_a(d0, 60 * DIV_A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_timeout: got no done want done"); end
    checks++; if (frame_at_done_a !== 16'h54C3) begin errors++; $display("FAIL write_frame: got %h want 54c3", frame_at_done_a); end
    checks++; if (cs_low_at_done_a != 34 * DIV_A) begin errors++; $display("FAIL write_cs_low: got %0d want %0d", cs_low_at_done_a, 34 * DIV_A); end
    checks++; if (done_cyc_a - acc != 34 * DIV_A + 1) begin errors++; $display("FAIL write_latency: got %0d want %0d", done_cyc_a - acc, 34 * DIV_A + 1); end
    checks++; if (rdata_at_done_a !== rd_model) begin errors++; $display("FAIL write_rdata: got %h want %h", rdata_at_done_a, rd_model); end
    checks++; if (busy_at_done_a !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b want 0", busy_at_done_a); end
    $display("txn write addr=2a wdata=c3 frame=%h latency=%0d", frame_at_done_a, done_cyc_a - acc);
    repeat (2 * DIV_A + 2) @(posedge clk);
  endtask

  task automatic test_read();
    int acc; bit ok; int d0;
    d0 = done_cnt_a;
    launch_a(7'h05, 1'b1, 8'h77, 8'hA5, acc);
    rd_model = 8'hA5;
    wait_done_a(d0, 60 * DIV_A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_timeout: got no done want done"); end
    checks++; if (frame_at_done_a !== 16'h0B00) begin errors++; $display("FAIL read_frame: got %h want 0b00", frame_at_done_a); end
    checks++; if (rdata_at_done_a !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h want a5", rdata_at_done_a); end
    checks++; if (done_cyc_a - acc != 34 * DIV_A + 1) begin errors++; $display("FAIL read_latency: got %0d want %0d", done_cyc_a - acc, 34 * DIV_A + 1); end
    $display("txn read addr=05 frame=%h rdata=%h", frame_at_done_a, rdata_at_done_a);
    repeat (2 * DIV_A + 2) @(posedge clk);
  endtask

  task automatic test_random();
    int acc; bit ok; int d0;
    logic [6:0] a; logic r; logic [7:0] w, s;
    for (int n = 0; n < 8; n++) begin
      a = 7'($urandom); r = 1'($urandom); w = 8'($urandom); s = 8'($urandom);
      d0 = done_cnt_a;
      launch_a(a, r, w, s, acc);
      if (r) rd_model = s;
      // inputs wander after accept; the frame in flight must not notice
      bus_a.addr = 7'($urandom); bus_a.rw = 1'($urandom); bus_a.wdata = 8'($urandom);
      wait_done_a(d0, 60 * DIV_A, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: got no done want done", n); end
      checks++; if (frame_at_done_a !== exp_frame(a, r, w))
        begin errors++; $display("FAIL rand_frame[%0d]: got %h want %h", n, frame_at_done_a, exp_frame(a, r, w)); end
      checks++; if (rdata_at_done_a !== rd_model)
        begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdata_at_done_a, rd_model); end
      checks++; if (done_cyc_a - acc != 34 * DIV_A + 1)
        begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, done_cyc_a - acc, 34 * DIV_A + 1); end
      $display("txn random[%0d] addr=%h rw=%0d wdata=%h frame=%h rdata=%h", n, a, r, w, frame_at_done_a, rdata_at_done_a);
      repeat (2 * DIV_A + 2) @(posedge clk);
    end
  endtask

  task automatic test_start_busy();
    int acc; bit ok; int d0, f0;
    d0 = done_cnt_a;
    f0 = cs_fall_a;
    launch_a(7'h33, 1'b0, 8'h5A, 8'h00, acc);
    wait_falls_a(3, 40 * DIV_A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_bit3_timeout: got fall count %0d want 3", fall_a); end
    bus_a.addr = 7'h7F; bus_a.rw = 1'b1; bus_a.wdata = 8'hFF; bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    wait_done_a(d0, 60 * DIV_A, ok);
    repeat (60 * DIV_A) @(posedge clk);
    #1;
    checks++; if (frame_at_done_a !== 16'h665A) begin errors++; $display("FAIL busy_frame: got %h want 665a", frame_at_done_a); end
    checks++; if (done_cnt_a - d0 != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt_a - d0); end
    checks++; if (cs_fall_a - f0 != 1) begin errors++; $display("FAIL busy_frame_count: got %0d want 1", cs_fall_a - f0); end
    $display("txn start-while-busy frame=%h dones=%0d", frame_at_done_a, done_cnt_a - d0);
  endtask

  task automatic test_back_to_back();
    bit ok; int d0, f0;
    gap_q.delete();
    done_q.delete();
    d0 = done_cnt_a;
    f0 = cs_fall_a;
    @(posedge clk); #1;
    sb_a = 8'h3C;
    bus_a.addr = 7'h41; bus_a.rw = 1'b1; bus_a.wdata = 8'h00; bus_a.start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 120 * DIV_A && !ok; i++) begin
      @(posedge clk); #1;
      if (cs_fall_a >= f0 + 3) ok = 1'b1;
    end
    bus_a.start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept_timeout: got %0d frames want 3", cs_fall_a - f0); end
    wait_done_a(d0 + 2, 60 * DIV_A, ok);
    repeat (8 * DIV_A) @(posedge clk);
    #1;
    rd_model = 8'h3C;
    checks++; if (done_cnt_a - d0 != 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt_a - d0); end
    checks++; if (cs_fall_a - f0 != 3) begin errors++; $display("FAIL b2b_frame_count: got %0d want 3", cs_fall_a - f0); end
    checks++;
    if (gap_q.size() < 3 || done_q.size() < 3) begin
      errors++; $display("FAIL b2b_history: got gaps=%0d dones=%0d want 3 and 3", gap_q.size(), done_q.size());
    end else begin
      for (int g = 1; g < 3; g++) begin
        checks++; if (gap_q[g] != 2 * DIV_A)
          begin errors++; $display("FAIL b2b_cs_high[%0d]: got %0d want %0d", g, gap_q[g], 2 * DIV_A); end
        checks++; if (done_q[g] - done_q[g-1] != 36 * DIV_A)
          begin errors++; $display("FAIL b2b_done_spacing[%0d]: got %0d want %0d", g, done_q[g] - done_q[g-1], 36 * DIV_A); end
      end
    end
    checks++; if (rdata_at_done_a !== rd_model) begin errors++; $display("FAIL b2b_rdata: got %h want %h", rdata_at_done_a, rd_model); end
    $display("txn back-to-back frames=%0d dones=%0d", cs_fall_a - f0, done_cnt_a - d0);
  endtask

  task automatic test_reset_mid();
    int acc; bit ok; int d0, f0;
    d0 = done_cnt_a;
    launch_a(7'h6E, 1'b0, 8'h99, 8'h00, acc);
    wait_falls_a(5, 40 * DIV_A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_bit5_timeout: got fall count %0d want 5", fall_a); end
    reset = 1'b1;
    #1;
    checks++; if (bus_a.cs !== 1'b1 || bus_a.sclk !== 1'b0 || bus_a.busy !== 1'b0)
      begin errors++; $display("FAIL rstmid_immediate: got cs=%b sclk=%b busy=%b want 1 0 0", bus_a.cs, bus_a.sclk, bus_a.busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_model = 8'h00;
    f0 = cs_fall_a;
    repeat (60 * DIV_A) @(posedge clk);
    #1;
    checks++; if (done_cnt_a != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d dones want 0", done_cnt_a - d0); end
    checks++; if (cs_fall_a != f0) begin errors++; $display("FAIL rstmid_idle: got %0d frames want 0", cs_fall_a - f0); end
    launch_a(7'h12, 1'b0, 8'h00, 8'h00, acc);
    wait_done_a(d0, 60 * DIV_A, ok);
    checks++; if (frame_at_done_a !== 16'h2400) begin errors++; $display("FAIL rstmid_new_frame: got %h want 2400", frame_at_done_a); end
    checks++; if (done_cyc_a - acc != 34 * DIV_A + 1) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", done_cyc_a - acc, 34 * DIV_A + 1); end
    checks++; if (rdata_at_done_a !== 8'h00) begin errors++; $display("FAIL rstmid_rdata: got %h want 00", rdata_at_done_a); end
    $display("txn reset-mid-frame then write addr=12 frame=%h", frame_at_done_a);
    repeat (2 * DIV_A + 2) @(posedge clk);
  endtask

  task automatic test_div2();
    int acc; bit ok; int d0;
    logic [7:0] w;
    w = 8'($urandom);
    d0 = done_cnt_b;
    @(posedge clk); #1;
    bus_b.addr = 7'h5D; bus_b.rw = 1'b0; bus_b.wdata = w; bus_b.start = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 * DIV_B && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt_b > d0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL div2_timeout: got no done want done"); end
    checks++; if (per_min_b != 2 * DIV_B || per_max_b != 2 * DIV_B)
      begin errors++; $display("FAIL div2_sclk_period: got %0d..%0d want %0d", per_min_b, per_max_b, 2 * DIV_B); end
    checks++; if (done_cyc_b - acc != 34 * DIV_B + 1)
      begin errors++; $display("FAIL div2_latency: got %0d want %0d", done_cyc_b - acc, 34 * DIV_B + 1); end
    checks++; if (frame_at_done_b !== exp_frame(7'h5D, 1'b0, w))
      begin errors++; $display("FAIL div2_frame: got %h want %h", frame_at_done_b, exp_frame(7'h5D, 1'b0, w)); end
    $display("txn div2 write addr=5d wdata=%h frame=%h latency=%0d", w, frame_at_done_b, done_cyc_b - acc);
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.rw = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.start = 1'b0; bus_b.rw = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_random();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_div2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
